hex_sr_multi: RTL and testbench

- Parametrised multi-mode successor to the per-bit recirculating hex shift register.
- A WIDTH-bit-wide, LENGTH-deep word shift register with four modes: hold, shift-in, recirculate and zero-flush.
- Adds synchronous reset, a saturating fill counter and full flag, and a frame marker that flags when the first word written after reset/flush reaches the output.
- Sits behind the 8-bit tile IO wrapper, replacing the six independent bit-serial chains with one word-wide register.

---
 rtl/hex_sr_multi.sv | 76 +++++++
 tb/tb_hex_sr_multi.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hex_sr_multi.sv
// Word-wide recirculating shift register with hold/shift/recirculate/zero-flush modes,
// a saturating fill counter and a frame marker for the first word written after a clear.
module hex_sr_multi #(
  parameter int WIDTH  = 6,
  parameter int LENGTH = 100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    mode,
  input  logic [WIDTH-1:0]              data_in,
  output logic [WIDTH-1:0]              data_out,
  output logic [$clog2(LENGTH+1)-1:0]   fill_count,
  output logic                          full,
  output logic                          frame
);

  localparam int CW = $clog2(LENGTH+1);
  localparam int PW = $clog2(LENGTH);

  localparam logic [CW-1:0] FILL_MAX = CW'(LENGTH);
  localparam logic [PW-1:0] POS_LAST = PW'(LENGTH-1);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_RECIRC = 2'b10;
  localparam logic [1:0] MODE_ZERO   = 2'b11;

  logic [WIDTH-1:0] stage [LENGTH];
  logic [PW-1:0]    pos;
  logic [WIDTH-1:0] new_word;

  function automatic logic [CW-1:0] fill_sat_inc(input logic [CW-1:0] c);
    return (c == FILL_MAX) ? c : c + CW'(1);
  endfunction

  // LENGTH need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [PW-1:0] pos_wrap_inc(input logic [PW-1:0] p);
    return (p == POS_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    new_word = '0;
    case (mode)
      MODE_SHIFT:  new_word = data_in;
      MODE_RECIRC: new_word = stage[LENGTH-1];
      default:     new_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LENGTH; i++) stage[i] <= '0;
      pos        <= '0;
      fill_count <= '0;
    end else if (mode != MODE_HOLD) begin
      stage[0] <= new_word;
      for (int i = 1; i < LENGTH; i++) stage[i] <= stage[i-1];
      case (mode)
        MODE_SHIFT: begin
          pos        <= pos_wrap_inc(pos);
          fill_count <= fill_sat_inc(fill_count);
        end
        MODE_RECIRC: pos <= pos_wrap_inc(pos);
        default: begin
          pos        <= '0;
          fill_count <= '0;
        end
      endcase
    end
  end

  assign data_out = stage[LENGTH-1];
  assign full     = (fill_count == FILL_MAX);
  assign frame    = full && (pos == '0);

endmodule

// File: tb/tb_hex_sr_multi.sv
// Bench for hex_sr_multi: directed vectors on a LENGTH=4 instance plus random traffic on
// LENGTH=100/WIDTH=6 and LENGTH=5/WIDTH=1 instances, all checked against an array model.
module tb_hex_sr_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r0, r1, r2;
  logic [1:0] m0, m1, m2;
  logic [5:0] d0, d1;
  logic       d2;
  logic [5:0] o0, o1;
  logic       o2;
  logic [2:0] f0, f2;
  logic [6:0] f1;
  logic       fu0, fu1, fu2, fr0, fr1, fr2;

  hex_sr_multi #(.WIDTH(6), .LENGTH(4)) u0 (
    .clk(clk), .rst_n(r0), .mode(m0), .data_in(d0),
    .data_out(o0), .fill_count(f0), .full(fu0), .frame(fr0));
  hex_sr_multi #(.WIDTH(6), .LENGTH(100)) u1 (
    .clk(clk), .rst_n(r1), .mode(m1), .data_in(d1),
    .data_out(o1), .fill_count(f1), .full(fu1), .frame(fr1));
  hex_sr_multi #(.WIDTH(1), .LENGTH(5)) u2 (
    .clk(clk), .rst_n(r2), .mode(m2), .data_in(d2),
    .data_out(o2), .fill_count(f2), .full(fu2), .frame(fr2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one word array per instance, a fill count, and the number of
  // shifts since the last clear (the frame marker is at the output every LENGTH shifts).
  int         len [3] = '{4, 100, 5};
  logic [5:0] mem [3][100];
  int         fill [3];
  int         sc [3];
  bit         valid [3] = '{0, 0, 0};

  task automatic model_step(input int k, input bit rst, input logic [1:0] m, input logic [5:0] din);
    logic [5:0] nw;
    if (rst) begin
      for (int i = 0; i < len[k]; i++) mem[k][i] = 6'd0;
      fill[k] = 0;
      sc[k] = 0;
      valid[k] = 1'b1;
    end else if (m != 2'b00) begin
      nw = (m == 2'b01) ? din : (m == 2'b10) ? mem[k][len[k]-1] : 6'd0;
      for (int i = len[k]-1; i > 0; i--) mem[k][i] = mem[k][i-1];
      mem[k][0] = nw;
      if (m == 2'b11) begin
        fill[k] = 0;
        sc[k] = 0;
      end else begin
        sc[k] = sc[k] + 1;
        if (m == 2'b01 && fill[k] < len[k]) fill[k] = fill[k] + 1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, !r0, m0, d0);
    model_step(1, !r1, m1, d1);
    model_step(2, !r2, m2, {5'd0, d2});
  end

  task automatic check_inst(input int k, input logic [5:0] dout, input logic [6:0] fc,
                            input logic fu, input logic fr);
    bit efull;
    efull = (fill[k] == len[k]);
    chk($sformatf("i%0d data_out", k), 32'(dout), 32'(mem[k][len[k]-1]));
    chk($sformatf("i%0d fill_count", k), 32'(fc), 32'(fill[k]));
    chk($sformatf("i%0d full", k), 32'(fu), 32'(efull));
    chk($sformatf("i%0d frame", k), 32'(fr), 32'(efull && (sc[k] % len[k] == 0)));
  endtask

  always @(negedge clk) begin
    if (valid[0]) check_inst(0, o0, {4'd0, f0}, fu0, fr0);
    if (valid[1]) check_inst(1, o1, f1, fu1, fr1);
    if (valid[2]) check_inst(2, {5'd0, o2}, {4'd0, f2}, fu2, fr2);
  end

  // Directed stimulus on instance 0 (LENGTH=4).
  task automatic tick(input bit rn, input logic [1:0] m, input logic [5:0] d);
    r0 = rn; m0 = m; d0 = d;
    @(negedge clk);
  endtask

  task automatic expect0(input string tag, input int dout, input int fc, input bit fu, input bit fr);
    chk({tag, " data_out"}, 32'(o0), 32'(dout));
    chk({tag, " fill_count"}, 32'(f0), 32'(fc));
    chk({tag, " full"}, 32'(fu0), 32'(fu));
    chk({tag, " frame"}, 32'(fr0), 32'(fr));
    chk({tag, " model data_out"}, 32'(mem[0][3]), 32'(dout));
    chk({tag, " model fill"}, 32'(fill[0]), 32'(fc));
  endtask

  initial begin
    int rs [8];
    int zs [3];
    rs = '{2, 3, 4, 1, 2, 3, 4, 1};
    zs = '{4, 5, 0};
    r0 = 1'b1; m0 = 2'b00; d0 = 6'd0;
    @(negedge clk);
    tick(1, 2'b01, 6'h2A);
    tick(1, 2'b01, 6'h15);
    tick(0, 2'b01, 6'h3F);
    expect0("reset", 0, 0, 0, 0);
    tick(0, 2'b10, 6'h11);
    expect0("reset_recirc", 0, 0, 0, 0);
    tick(0, 2'b01, 6'h22);
    expect0("reset_shift", 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(1, 2'b01, 6'(i));
      expect0($sformatf("fill%0d", i), (i == 4) ? 1 : 0, i, i == 4, i == 4);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1, 2'b10, 6'h00);
      expect0($sformatf("recirc%0d", i), rs[i], 4, 1, rs[i] == 1);
      if (i == 1) begin
        for (int h = 0; h < 3; h++) begin
          tick(1, 2'b00, 6'h3F);
          expect0($sformatf("hold%0d", h), 3, 4, 1, 0);
        end
      end
    end
    tick(1, 2'b01, 6'h05);
    expect0("shift5", 2, 4, 1, 0);
    tick(1, 2'b11, 6'h3F);
    expect0("zero0", 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 2'b11, 6'h2A);
      expect0($sformatf("zero%0d", i + 1), zs[i], 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1, 2'b01, 6'h3F);
      expect0($sformatf("refill%0d", i), (i == 3) ? 6'h3F : 0, i + 1, i == 3, i == 3);
    end
    tick(1, 2'b00, 6'h00);
    repeat (3000) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Random traffic for the swept instances; long zero-free stretches let LENGTH=100 fill.
  function automatic logic [1:0] pick_mode(input bit allow_zero);
    int x;
    x = $urandom_range(99);
    if (x < 55) return 2'b01;
    if (x < 80) return 2'b10;
    if (x < 97 || !allow_zero) return 2'b00;
    return 2'b11;
  endfunction

  initial begin
    int cyc;
    bit wild;
    cyc = 0;
    r1 = 1'b0; r2 = 1'b0; m1 = 2'b00; m2 = 2'b00; d1 = 6'd0; d2 = 1'b0;
    repeat (2) @(negedge clk);
    forever begin
      cyc++;
      wild = (cyc % 1000) >= 600;
      r1 = !(wild && $urandom_range(299) == 0);
      r2 = !(wild && $urandom_range(299) == 0);
      m1 = pick_mode(wild);
      m2 = pick_mode(wild || (cyc % 50 == 0));
      d1 = 6'($urandom);
      d2 = 1'($urandom);
      @(negedge clk);
    end
  end

endmodule
